mem_bus_arbiter: RTL and testbench

Shares the single memory port between two requesters: instruction fetch (IFU) and load/store (LSU).
- Each requester has a valid/ready request channel and a valid/ready response channel.
- At most one transaction is outstanding. The request payload is registered at grant, and the response is routed back to the owner.
- Sits between the fetch/memory pipeline stages and the memory model/bus.

---
 rtl/mem_bus_arbiter_if.sv | 52 +++++
 rtl/mem_bus_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the IFU, LSU and memory-side handshake channels around mem_bus_arbiter.
// slave: arbiter view; master: requesters plus memory model view.
interface mem_bus_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MASK_WIDTH = 8
);
    logic                  ifu_req_valid;
    logic                  ifu_req_ready;
    logic [ADDR_WIDTH-1:0] ifu_addr;
    logic                  ifu_rsp_valid;
    logic                  ifu_rsp_ready;
    logic [DATA_WIDTH-1:0] ifu_rdata;

    logic                  lsu_req_valid;
    logic                  lsu_req_ready;
    logic [ADDR_WIDTH-1:0] lsu_addr;
    logic                  lsu_wen;
    logic [DATA_WIDTH-1:0] lsu_wdata;
    logic [MASK_WIDTH-1:0] lsu_wmask;
    logic                  lsu_rsp_valid;
    logic                  lsu_rsp_ready;
    logic [DATA_WIDTH-1:0] lsu_rdata;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_wen;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [MASK_WIDTH-1:0] mem_wmask;
    logic                  mem_rsp_valid;
    logic                  mem_rsp_ready;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  ifu_req_valid, ifu_addr, ifu_rsp_ready,
        output ifu_req_ready, ifu_rsp_valid, ifu_rdata,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_rsp_ready,
        output lsu_req_ready, lsu_rsp_valid, lsu_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_rsp_ready,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport master (
        output ifu_req_valid, ifu_addr, ifu_rsp_ready,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rdata,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_rsp_ready,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_rsp_ready,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester (IFU/LSU) arbiter for a single memory port, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN to alternate ties; default is fixed LSU priority.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MASK_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_bus_arbiter_if.slave      bus,
    output logic                  busy,
    output logic                  owner
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  wen;
        logic [DATA_WIDTH-1:0] wdata;
        logic [MASK_WIDTH-1:0] wmask;
    } req_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_owner;
    logic                  w_owner_nxt;
    req_t                  r_req;
    req_t                  w_req_nxt;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] w_rdata_nxt;
    logic                  w_pick_lsu;
    logic                  w_ifu_req_ready;
    logic                  w_lsu_req_ready;
    logic                  w_owner_rsp_ready;

    // Tie-break between simultaneous requests; r_owner doubles as the last grant.
`ifdef ARB_ROUND_ROBIN_EN
    assign w_pick_lsu = bus.lsu_req_valid && (!bus.ifu_req_valid || !r_owner);
`else
    assign w_pick_lsu = bus.lsu_req_valid;
`endif

    assign w_owner_rsp_ready = r_owner ? bus.lsu_rsp_ready : bus.ifu_rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_req   <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_req   <= w_req_nxt;
            r_rdata <= w_rdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_req_nxt       = r_req;
        w_rdata_nxt     = r_rdata;
        w_ifu_req_ready = 1'b0;
        w_lsu_req_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                // No grant while reset is asserted so nothing is accepted then lost.
                if (!rst && (bus.ifu_req_valid || bus.lsu_req_valid)) begin
                    w_state_nxt = S_GRANT;
                    if (w_pick_lsu) begin
                        w_lsu_req_ready = 1'b1;
                        w_owner_nxt     = 1'b1;
                        w_req_nxt       = '{addr:  bus.lsu_addr,
                                            wen:   bus.lsu_wen,
                                            wdata: bus.lsu_wdata,
                                            wmask: bus.lsu_wmask};
                    end else begin
                        w_ifu_req_ready = 1'b1;
                        w_owner_nxt     = 1'b0;
                        w_req_nxt       = '{addr:  bus.ifu_addr,
                                            wen:   1'b0,
                                            wdata: '0,
                                            wmask: '0};
                    end
                end
            end
            S_GRANT: begin
                if (bus.mem_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.mem_rsp_valid) begin
                    w_rdata_nxt = bus.mem_rdata;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (w_owner_rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.ifu_req_ready = w_ifu_req_ready;
    assign bus.lsu_req_ready = w_lsu_req_ready;

    assign bus.mem_req_valid = (r_state == S_GRANT);
    assign bus.mem_addr      = r_req.addr;
    assign bus.mem_wen       = r_req.wen;
    assign bus.mem_wdata     = r_req.wdata;
    assign bus.mem_wmask     = r_req.wmask;
    assign bus.mem_rsp_ready = (r_state == S_WAIT);

    assign bus.ifu_rsp_valid = (r_state == S_RESP) && !r_owner;
    assign bus.lsu_rsp_valid = (r_state == S_RESP) &&  r_owner;
    assign bus.ifu_rdata     = r_rdata;
    assign bus.lsu_rdata     = r_rdata;

    assign busy  = (r_state != S_IDLE);
    assign owner = r_owner;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch, store with backpressure, ties, response stall, mid-flight reset.
module tb_mem_bus_arbiter;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned MASK_WIDTH = 8;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    logic rst;
    logic busy;
    logic owner;
    int   n_checks;
    int   n_errors;
    logic exp_first_lsu;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_c;

    mem_bus_arbiter_if #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .MASK_WIDTH(MASK_WIDTH)
    ) bus ();

    mem_bus_arbiter #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .MASK_WIDTH(MASK_WIDTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .busy  (busy),
        .owner (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.ifu_req_valid = 1'b0;
        bus.ifu_addr      = '0;
        bus.ifu_rsp_ready = 1'b0;
        bus.lsu_req_valid = 1'b0;
        bus.lsu_addr      = '0;
        bus.lsu_wen       = 1'b0;
        bus.lsu_wdata     = '0;
        bus.lsu_wmask     = '0;
        bus.lsu_rsp_ready = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        do_reset();
        #1;
        check_eq("rst_busy",      64'(busy), 64'd0);
        check_eq("rst_owner",     64'(owner), 64'd0);
        check_eq("rst_ifu_rdy",   64'(bus.ifu_req_ready), 64'd0);
        check_eq("rst_lsu_rdy",   64'(bus.lsu_req_ready), 64'd0);
        check_eq("rst_mreq_v",    64'(bus.mem_req_valid), 64'd0);
        check_eq("rst_mrsp_rdy",  64'(bus.mem_rsp_ready), 64'd0);
        check_eq("rst_ifu_rsp_v", 64'(bus.ifu_rsp_valid), 64'd0);
        check_eq("rst_lsu_rsp_v", 64'(bus.lsu_rsp_valid), 64'd0);

        // IFU fetch, zero-wait memory
        nxt();
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0000;
        bus.mem_req_ready = 1'b1;
        bus.ifu_rsp_ready = 1'b1;
        #1;
        check_eq("f0_ifu_rdy", 64'(bus.ifu_req_ready), 64'd1);
        check_eq("f0_lsu_rdy", 64'(bus.lsu_req_ready), 64'd0);
        nxt();
        bus.ifu_req_valid = 1'b0;
        #1;
        check_eq("f1_mreq_v",  64'(bus.mem_req_valid), 64'd1);
        check_eq("f1_maddr",   64'(bus.mem_addr), 64'h8000_0000);
        check_eq("f1_mwen",    64'(bus.mem_wen), 64'd0);
        check_eq("f1_busy",    64'(busy), 64'd1);
        check_eq("f1_ifu_rdy", 64'(bus.ifu_req_ready), 64'd0);
        nxt();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'h0000_0413;
        #1;
        check_eq("f2_mrsp_rdy", 64'(bus.mem_rsp_ready), 64'd1);
        check_eq("f2_mreq_v",   64'(bus.mem_req_valid), 64'd0);
        nxt();
        bus.mem_rsp_valid = 1'b0;
        #1;
        check_eq("f3_ifu_rsp_v", 64'(bus.ifu_rsp_valid), 64'd1);
        check_eq("f3_ifu_rdata", 64'(bus.ifu_rdata), 64'h0000_0413);
        check_eq("f3_lsu_rsp_v", 64'(bus.lsu_rsp_valid), 64'd0);
        nxt();
        #1;
        check_eq("f4_busy",      64'(busy), 64'd0);
        check_eq("f4_ifu_rsp_v", 64'(bus.ifu_rsp_valid), 64'd0);

        // LSU store with 3 cycles of request backpressure
        nxt();
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 32'h8000_1000;
        bus.lsu_wen       = 1'b1;
        bus.lsu_wdata     = 32'hDEAD_BEEF;
        bus.lsu_wmask     = 8'h0F;
        bus.mem_req_ready = 1'b0;
        bus.lsu_rsp_ready = 1'b1;
        #1;
        check_eq("s0_lsu_rdy", 64'(bus.lsu_req_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            nxt();
            bus.lsu_req_valid = 1'b0;
            bus.lsu_wdata     = 32'h0;
            bus.mem_req_ready = (i == 3);
            #1;
            check_eq("s_mreq_v",  64'(bus.mem_req_valid), 64'd1);
            check_eq("s_maddr",   64'(bus.mem_addr), 64'h8000_1000);
            check_eq("s_mwen",    64'(bus.mem_wen), 64'd1);
            check_eq("s_mwdata",  64'(bus.mem_wdata), 64'hDEAD_BEEF);
            check_eq("s_mwmask",  64'(bus.mem_wmask), 64'h0F);
        end
        nxt();
        bus.mem_req_ready = 1'b0;
        #1;
        check_eq("s5_mrsp_rdy",  64'(bus.mem_rsp_ready), 64'd1);
        check_eq("s5_lsu_rsp_v", 64'(bus.lsu_rsp_valid), 64'd0);
        nxt();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'h1234_5678;
        #1;
        check_eq("s6_lsu_rsp_v", 64'(bus.lsu_rsp_valid), 64'd0);
        nxt();
        bus.mem_rsp_valid = 1'b0;
        #1;
        check_eq("s7_lsu_rsp_v", 64'(bus.lsu_rsp_valid), 64'd1);
        check_eq("s7_lsu_rdata", 64'(bus.lsu_rdata), 64'h1234_5678);
        check_eq("s7_ifu_rsp_v", 64'(bus.ifu_rsp_valid), 64'd0);
        check_eq("s7_owner",     64'(owner), 64'd1);
        nxt();
        #1;
        check_eq("s8_busy",  64'(busy), 64'd0);
        check_eq("s8_owner", 64'(owner), 64'd1);

        // Simultaneous requests after reset, then LSU response stall
        do_reset();
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0100;
        bus.ifu_rsp_ready = 1'b1;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 32'h8000_2000;
        bus.lsu_wen       = 1'b0;
        bus.mem_req_ready = 1'b1;
        bus.lsu_rsp_ready = 1'b0;
        #1;
        check_eq("t0_lsu_rdy", 64'(bus.lsu_req_ready), 64'd1);
        check_eq("t0_ifu_rdy", 64'(bus.ifu_req_ready), 64'd0);
        nxt();
        bus.lsu_req_valid = 1'b0;
        #1;
        check_eq("t1_maddr",   64'(bus.mem_addr), 64'h8000_2000);
        check_eq("t1_owner",   64'(owner), 64'd1);
        check_eq("t1_ifu_rdy", 64'(bus.ifu_req_ready), 64'd0);
        nxt();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'hCAFE_F00D;
        nxt();
        bus.mem_rsp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                bus.lsu_req_valid = 1'b1;
                bus.lsu_addr      = 32'h8000_3000;
            end
            #1;
            check_eq("bp_lsu_rsp_v", 64'(bus.lsu_rsp_valid), 64'd1);
            check_eq("bp_lsu_rdata", 64'(bus.lsu_rdata), 64'hCAFE_F00D);
            check_eq("bp_ifu_rdy",   64'(bus.ifu_req_ready), 64'd0);
            check_eq("bp_lsu_rdy",   64'(bus.lsu_req_ready), 64'd0);
            nxt();
        end
        bus.lsu_rsp_ready = 1'b1;
        #1;
        check_eq("bp_hs_lsu_rsp_v", 64'(bus.lsu_rsp_valid), 64'd1);

        // Second tie, last owner LSU: fixed priority picks LSU, round robin picks IFU
        exp_first_lsu = !RR;
        addr_a = 32'h8000_0100;
        addr_c = 32'h8000_3000;
        nxt();
        #1;
        check_eq("t2_lsu_rdy", 64'(bus.lsu_req_ready), 64'(exp_first_lsu));
        check_eq("t2_ifu_rdy", 64'(bus.ifu_req_ready), 64'(!exp_first_lsu));
        nxt();
        if (exp_first_lsu) bus.lsu_req_valid = 1'b0;
        else               bus.ifu_req_valid = 1'b0;
        #1;
        check_eq("t3_maddr", 64'(bus.mem_addr), 64'(exp_first_lsu ? addr_c : addr_a));
        check_eq("t3_owner", 64'(owner), 64'(exp_first_lsu));
        nxt();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'h1111_1111;
        nxt();
        bus.mem_rsp_valid = 1'b0;
        #1;
        check_eq("t5_lsu_rsp_v", 64'(bus.lsu_rsp_valid), 64'(exp_first_lsu));
        check_eq("t5_ifu_rsp_v", 64'(bus.ifu_rsp_valid), 64'(!exp_first_lsu));
        nxt();
        #1;
        check_eq("t6_lsu_rdy", 64'(bus.lsu_req_ready), 64'(!exp_first_lsu));
        check_eq("t6_ifu_rdy", 64'(bus.ifu_req_ready), 64'(exp_first_lsu));
        nxt();
        bus.lsu_req_valid = 1'b0;
        bus.ifu_req_valid = 1'b0;
        #1;
        check_eq("t7_maddr", 64'(bus.mem_addr), 64'(exp_first_lsu ? addr_a : addr_c));
        nxt();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'h2222_2222;
        nxt();
        bus.mem_rsp_valid = 1'b0;
        #1;
        check_eq("t9_lsu_rsp_v", 64'(bus.lsu_rsp_valid), 64'(!exp_first_lsu));
        check_eq("t9_ifu_rsp_v", 64'(bus.ifu_rsp_valid), 64'(exp_first_lsu));
        check_eq("t9_rdata",     64'(exp_first_lsu ? bus.ifu_rdata : bus.lsu_rdata), 64'h2222_2222);
        nxt();
        #1;
        check_eq("t10_busy", 64'(busy), 64'd0);

        // Reset while waiting for an LSU load response
        nxt();
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 32'h8000_4000;
        bus.lsu_wen       = 1'b0;
        bus.mem_req_ready = 1'b1;
        #1;
        check_eq("r0_lsu_rdy", 64'(bus.lsu_req_ready), 64'd1);
        nxt();
        bus.lsu_req_valid = 1'b0;
        #1;
        check_eq("r1_mreq_v", 64'(bus.mem_req_valid), 64'd1);
        nxt();
        #1;
        check_eq("r2_mrsp_rdy", 64'(bus.mem_rsp_ready), 64'd1);
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        #1;
        check_eq("r3_busy",     64'(busy), 64'd0);
        check_eq("r3_mrsp_rdy", 64'(bus.mem_rsp_ready), 64'd0);
        check_eq("r3_owner",    64'(owner), 64'd0);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'h5555_AAAA;
        #1;
        check_eq("r3_lsu_rsp_v", 64'(bus.lsu_rsp_valid), 64'd0);
        nxt();
        #1;
        check_eq("r4_lsu_rsp_v", 64'(bus.lsu_rsp_valid), 64'd0);
        check_eq("r4_ifu_rsp_v", 64'(bus.ifu_rsp_valid), 64'd0);
        check_eq("r4_busy",      64'(busy), 64'd0);
        bus.mem_rsp_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
